// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: 2-bit FSM state encoding and the default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receive-side bundle between start detector / serial line, frame controller and host.
// Latency: n/a (wiring only).
// Backpressure: rx_valid is a level held until the host pulses rx_ack.
// Modports: master = frame controller (drives rx_data, rx_valid, error pulses, busy);
//           slave  = environment (drives rx_in, start_detected, rx_ack).
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic                 start_detected;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx_in, start_detected, rx_ack,
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    output rx_in, start_detected, rx_ack,
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Bit timer: counts OVERSAMPLE ticks per bit and tracks how many data bits were sampled.
// Latency: sample_strobe is combinational from the registered tick count (every OVERSAMPLE ticks).
// Backpressure: none; clear dominates enable.
// Ports: baud_clk/rst, clear (hold counters at 0), enable (count), sample_strobe (tick top
//        reached this cycle), last_bit (the strobe, if any, samples the final data bit).
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic baud_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic sample_strobe,
  output logic last_bit
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_TOP = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(DATA_BITS);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    if (clear) begin
      tick_cnt_d = '0;
      bit_idx_d  = '0;
    end else if (enable) begin
      if (tick_cnt_q == TICK_TOP) begin
        tick_cnt_d = '0;
        // Saturate once all data bits are in; parity/stop samples reuse the tick count only.
        if (bit_idx_q != IDX_END) begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  assign sample_strobe = enable & ~clear & (tick_cnt_q == TICK_TOP);
  assign last_bit      = (bit_idx_q == IDX_LAST);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Receive frame sequencer: on a start edge, samples DATA_BITS bits LSB first at mid-bit, checks stop, hands byte to host.
// Latency: stop sampled at T0 + OVERSAMPLE*(DATA_BITS+1) (+OVERSAMPLE with parity); rx_valid/errors update on that edge.
// Backpressure: rx_valid holds until rx_ack; a byte completing while rx_valid is held (no ack) is dropped with an overrun pulse.
// Ports: baud_clk (16x clock), rst (async, active-high), bus (master modport: rx_in, start_detected, rx_ack in;
//        rx_data, rx_valid, frame_err, parity_err, overrun, busy out).
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit between data and stop (PARITY_ODD selects odd).
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                baud_clk,
  input logic                rst,
  uart_rx_frame_ctrl_if.master bus
);

  state_e               state_q, state_d;
  logic                 start_q;
  logic                 trigger;
  logic                 timer_clear, timer_en;
  logic                 sample_strobe, last_bit;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Only a fresh rising edge starts a frame; start_q resets high so a detect
  // already asserted during reset is not mistaken for a new start.
  assign trigger = bus.start_detected & ~start_q;

  assign timer_clear = (state_q == IDLE);
  assign timer_en    = ~timer_clear;

  uart_rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) u_bit_timer (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .clear         (timer_clear),
    .enable        (timer_en),
    .sample_strobe (sample_strobe),
    .last_bit      (last_bit)
  );

  // State register
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trigger) state_d = DATA;
      end
      DATA: begin
        if (sample_strobe && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_strobe) state_d = STOP;
      end
`endif
      STOP: begin
        if (sample_strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    // An ack only matters while a byte is pending.
    rx_valid_d  = rx_valid_q & ~bus.rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      DATA: begin
        // LSB arrives first, so shifting right with new bits at the MSB
        // leaves the byte in natural order after DATA_BITS samples.
        if (sample_strobe) shift_d = {bus.rx_in, shift_q[DATA_BITS-1:1]};
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_strobe) par_bad_d = ((^shift_q) ^ PARITY_ODD) != bus.rx_in;
      end
`endif
      STOP: begin
        if (sample_strobe) begin
          if (!bus.rx_in) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q) begin
            parity_err_d = 1'b1;
          end
`endif
          else if (!rx_valid_q || bus.rx_ack) begin
            // Same-cycle ack frees the holding register for the new byte.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b1;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      start_q     <= bus.start_detected;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  // Parity checking is compiled out, so PARITY_ODD has no effect here.
  assign bus.parity_err = PARITY_ODD & 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames plus random frames, scoreboard of expected output events.
module tb_uart_rx_frame_ctrl;
  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam bit PODD = 1'b0;

  logic baud_clk = 1'b0;
  logic rst      = 1'b1;
  always #5 baud_clk = ~baud_clk;

  uart_rx_frame_ctrl_if #(.DATA_BITS(DB)) bus();

  uart_rx_frame_ctrl #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .PARITY_ODD (PODD)
  ) dut (
    .baud_clk (baud_clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    int          cyc;
    logic        vld;
    logic [DB-1:0] dat;
    logic        ferr;
    logic        ovr;
    logic        perr;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  // Reference model of the host-visible holding register.
  logic          m_vld;
  logic [DB-1:0] m_dat;

  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void push(input int c, input logic v, input logic [DB-1:0] d,
                               input logic fe, input logic ov, input logic pe);
    exp_t e;
    e.cyc = c; e.vld = v; e.dat = d; e.ferr = fe; e.ovr = ov; e.perr = pe;
    sbq.push_back(e);
  endfunction

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic do_ack();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    if (m_vld) begin
      m_vld = 1'b0;
      push(cyc, 1'b0, m_dat, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One frame: trigger edge, data bits, optional parity, stop. Expectation is
  // derived from the frame contents and the model's pending state.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_flip,
                            input logic ack_at_stop, input int hold_low);
    logic par_bad;
    logic nv;
    bus.start_detected = 1'b1;
    bus.rx_in = 1'b0;
    tick();                                   // T0
    if (hold_low == 0) bus.start_detected = 1'b0;
    for (int k = 0; k < DB; k++) begin
      bus.rx_in = d[k];
      repeat (OS) tick();
      if (k == 0) check("busy_in_frame", 32'(bus.busy), 32'd1);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx_in = (^d) ^ PODD ^ par_flip;
    repeat (OS) tick();
    par_bad = par_flip;
`else
    par_bad = 1'b0;
`endif
    bus.rx_in = stop_b;
    repeat (OS - 1) tick();
    bus.rx_ack = ack_at_stop;
    tick();                                   // stop-sample edge
    bus.rx_ack = 1'b0;
    nv = m_vld & ~ack_at_stop;
    if (!stop_b) begin
      m_vld = nv;
      push(cyc, m_vld, m_dat, 1'b1, 1'b0, par_bad);
    end else if (par_bad) begin
      m_vld = nv;
      push(cyc, m_vld, m_dat, 1'b0, 1'b0, 1'b1);
    end else if (!m_vld || ack_at_stop) begin
      m_vld = 1'b1;
      m_dat = d;
      push(cyc, 1'b1, d, 1'b0, 1'b0, 1'b0);
    end else begin
      push(cyc, 1'b1, m_dat, 1'b0, 1'b1, 1'b0);
    end
    if (hold_low > 0) begin
      bus.rx_in = 1'b0;
      repeat (hold_low) tick();
      check("no_retrigger_busy", 32'(bus.busy), 32'd0);
      bus.start_detected = 1'b0;
    end
    bus.rx_in = 1'b1;
    if (hold_low > 0) tick();
  endtask

  // Monitor: pops an expectation whenever the DUT output changes or an expected event is due.
  logic          pv;
  logic [DB-1:0] pd;
  logic          changed;
  exp_t          e;
  always @(negedge baud_clk) begin
    if (rst) begin
      pv = bus.rx_valid;
      pd = bus.rx_data;
    end else begin
      changed = (bus.rx_valid !== pv) || (bus.rx_data !== pd) ||
                bus.frame_err || bus.overrun || bus.parity_err;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        check("event_time", 32'(cyc), 32'(sbq[0].cyc));
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        check("rx_valid",   32'(bus.rx_valid),   32'(e.vld));
        check("rx_data",    32'(bus.rx_data),    32'(e.dat));
        check("frame_err",  32'(bus.frame_err),  32'(e.ferr));
        check("overrun",    32'(bus.overrun),    32'(e.ovr));
        check("parity_err", 32'(bus.parity_err), 32'(e.perr));
        check("busy_idle",  32'(bus.busy),       32'd0);
      end else if (changed) begin
        check("unexpected_output",
              32'({bus.rx_valid, bus.frame_err, bus.overrun, bus.parity_err, bus.rx_data}),
              32'({pv, 3'b000, pd}));
      end
      pv = bus.rx_valid;
      pd = bus.rx_data;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] rd;
    logic          rs, rf;
    int            sel;
    bus.rx_in = 1'b1;
    bus.start_detected = 1'b1;                // held high through reset
    bus.rx_ack = 1'b0;
    m_vld = 1'b0;
    m_dat = '0;
    repeat (3) tick();
    check("reset_rx_valid",   32'(bus.rx_valid),   32'd0);
    check("reset_rx_data",    32'(bus.rx_data),    32'd0);
    check("reset_frame_err",  32'(bus.frame_err),  32'd0);
    check("reset_overrun",    32'(bus.overrun),    32'd0);
    check("reset_parity_err", 32'(bus.parity_err), 32'd0);
    check("reset_busy",       32'(bus.busy),       32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("held_detect_no_start", 32'(bus.busy), 32'd0);
    bus.start_detected = 1'b0;
    tick();

    // 1: clean frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) tick();
    // 2: framing error, line and detect held low/high for 64 more ticks
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 64);
    // 3: back-to-back without ack -> overrun on the second
    do_ack();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
    // 4: ack on the stop-sample edge loads the new byte
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 0);
    repeat (3) tick();

    // 5: reset during data bit 3 with detect high
    bus.start_detected = 1'b1;
    bus.rx_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.rx_in = k[0];
      repeat (OS) tick();
    end
    repeat (OS / 2) tick();
    rst = 1'b1;
    m_vld = 1'b0;
    m_dat = '0;
    #2;
    check("midrst_rx_valid",  32'(bus.rx_valid),  32'd0);
    check("midrst_rx_data",   32'(bus.rx_data),   32'd0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    check("midrst_overrun",   32'(bus.overrun),   32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (40) tick();
    check("midrst_no_trigger", 32'(bus.busy), 32'd0);
    bus.start_detected = 1'b0;
    bus.rx_in = 1'b1;
    tick();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) tick();

`ifdef UART_RX_PARITY_EN
    // 6: even parity, good then bad
    do_ack();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0);
    do_ack();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0);
    repeat (3) tick();
`endif

    // Random frames with random stop bits, parity corruption and ack timing.
    for (int i = 0; i < 30; i++) begin
      rd  = DB'($urandom);
      rs  = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      rf  = ($urandom_range(0, 3) == 0);
`else
      rf  = 1'b0;
`endif
      sel = $urandom_range(0, 2);
      if (sel == 1) do_ack();
      repeat ($urandom_range(0, 5)) tick();
      send_frame(rd, rs, rf, sel == 2, 0);
    end

    repeat (20) tick();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
